// File: rtl/gcd_operand_feeder.sv
`default_nettype none
// ============================================================================
// gcd_operand_feeder: FIFO-buffered operand sequencer and result capture for
// the GCD core, with a WAIT watchdog. Optional feature macro: GCD_ZERO_BYPASS_EN
// Revision: 1.0
// ============================================================================
module gcd_operand_feeder #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_gcd,
  output logic                   out_err,
  output logic                   gcd_start,
  output logic [WIDTH-1:0]       gcd_data_in,
  input  logic                   gcd_done,
  input  logic [WIDTH-1:0]       gcd_result,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST    = WDW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_WAIT   = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_gcd_q, out_gcd_d;
  logic             out_err_q, out_err_d;

  logic [WIDTH-1:0] fifo_a_mem [DEPTH];
  logic [WIDTH-1:0] fifo_b_mem [DEPTH];

  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;

  assign fifo_empty = (count_q == '0);
  assign head_a     = fifo_a_mem[rd_ptr_q];
  assign head_b     = fifo_b_mem[rd_ptr_q];

  // A slot freed by this cycle's pop may be refilled in the same cycle.
  assign in_ready = (count_q < FULL_COUNT) || pop;
  assign push     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_mem[wr_ptr_q] <= in_a;
      fifo_b_mem[wr_ptr_q] <= in_b;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    wd_d        = wd_q;
    out_valid_d = out_valid_q;
    out_gcd_d   = out_gcd_q;
    out_err_d   = out_err_q;
    pop         = 1'b0;

    case (state_q)
      S_IDLE: begin
        pop = !fifo_empty;
      end
      S_LOAD_A: begin
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (gcd_done) begin
          out_gcd_d   = gcd_result;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else if (wd_q == WD_LAST) begin
          out_gcd_d   = '0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (fifo_empty) begin
            state_d = S_IDLE;
          end else begin
            pop = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pop) begin
      a_d     = head_a;
      b_d     = head_b;
      state_d = S_LOAD_A;
`ifdef GCD_ZERO_BYPASS_EN
      // A zero operand would hang the core; answer directly with the other one.
      if ((head_a == '0) || (head_b == '0)) begin
        out_gcd_d   = head_a | head_b;
        out_err_d   = 1'b0;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
`endif
    end
  end

  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      wd_q        <= '0;
      out_valid_q <= 1'b0;
      out_gcd_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      a_q         <= a_d;
      b_q         <= b_d;
      wd_q        <= wd_d;
      out_valid_q <= out_valid_d;
      out_gcd_q   <= out_gcd_d;
      out_err_q   <= out_err_d;
    end
  end

  always_comb begin
    case (state_q)
      S_LOAD_A:        gcd_data_in = a_q;
      S_LOAD_B, S_WAIT: gcd_data_in = b_q;
      default:         gcd_data_in = '0;
    endcase
  end

  assign gcd_start  = (state_q == S_LOAD_A);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = out_valid_q;
  assign out_gcd    = out_gcd_q;
  assign out_err    = out_err_q;
  assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_gcd_operand_feeder.sv
`default_nettype none
// ============================================================================
// tb_gcd_operand_feeder: randomized and directed bench with a behavioural GCD
// core and an in-order result scoreboard. Honours GCD_ZERO_BYPASS_EN.
// Revision: 1.0
// ============================================================================
module tb_gcd_operand_feeder;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam logic [WIDTH-1:0] HANG_A = 16'hFFFF;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_gcd;
  logic             out_err;
  logic             gcd_start;
  logic [WIDTH-1:0] gcd_data_in;
  logic             gcd_done = 1'b0;
  logic [WIDTH-1:0] gcd_result = '0;
  logic             busy;
  logic [CW-1:0]    fifo_count;

  gcd_operand_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd), .out_err(out_err),
    .gcd_start(gcd_start), .gcd_data_in(gcd_data_in),
    .gcd_done(gcd_done), .gcd_result(gcd_result),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [WIDTH-1:0] a; logic [WIDTH-1:0] b; } pair_t;
  typedef struct packed { logic [WIDTH-1:0] gcd; logic err; } res_t;

  pair_t            issue_q [$];
  res_t             res_q   [$];
  logic [WIDTH-1:0] got_q   [$];
  int               tests = 0;
  int               fails = 0;
  bit               rand_done;
  logic [WIDTH-1:0] ra, rb;
  time              t_lb;
  int               nstart;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] gcd_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x = a;
    logic [WIDTH-1:0] y = b;
    logic [WIDTH-1:0] t;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic bit bypassed(input pair_t p);
`ifdef GCD_ZERO_BYPASS_EN
    return (p.a == '0) || (p.b == '0);
`else
    return 1'b0;
`endif
  endfunction

  // The modelled core never finishes on a zero operand or the magic A value.
  function automatic bit core_hangs(input pair_t p);
    return (p.a == HANG_A) || (p.a == '0) || (p.b == '0);
  endfunction

  function automatic res_t expect_res(input pair_t p);
    res_t r;
    if (bypassed(p)) begin
      r.gcd = p.a | p.b;
      r.err = 1'b0;
    end else if (core_hangs(p)) begin
      r.gcd = '0;
      r.err = 1'b1;
    end else begin
      r.gcd = gcd_f(p.a, p.b);
      r.err = 1'b0;
    end
    return r;
  endfunction

  initial begin : monitor
    logic  pv, pr;
    pair_t p;
    pv = 1'b0;
    pr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        pr = 1'b0;
      end else begin
        if (in_valid && in_ready) begin
          p.a = in_a;
          p.b = in_b;
          res_q.push_back(expect_res(p));
          if (!bypassed(p)) issue_q.push_back(p);
        end
        if (fifo_count < CW'(DEPTH)) check("in_ready_not_full", 32'(in_ready), 32'd1);
        if (pv && !pr) check("out_valid_held", 32'(out_valid), 32'd1);
        if (gcd_start) check("start_with_result_pending", 32'(out_valid), 32'd0);
        if (out_valid) begin
          if (res_q.size() == 0) begin
            check("unexpected_result", 32'(out_valid), 32'd0);
          end else begin
            check("out_gcd", 32'(out_gcd), 32'(res_q[0].gcd));
            check("out_err", 32'(out_err), 32'(res_q[0].err));
            if (out_ready) begin
              got_q.push_back(out_gcd);
              void'(res_q.pop_front());
            end
          end
        end
        pv = out_valid;
        pr = out_ready;
      end
    end
  end

  initial begin : core_model
    int    phase;
    int    delay;
    pair_t cur;
    phase = 0;
    delay = 0;
    cur   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase    = 0;
        gcd_done = 1'b0;
      end else if (gcd_start) begin
        gcd_done   = 1'b0;
        gcd_result = WIDTH'($urandom);
        if (issue_q.size() == 0) begin
          check("unexpected_start", 32'(gcd_start), 32'd0);
          phase = 0;
        end else begin
          cur = issue_q.pop_front();
          check("start_data_a", 32'(gcd_data_in), 32'(cur.a));
          phase = 1;
        end
      end else if (phase == 1) begin
        check("load_b_data", 32'(gcd_data_in), 32'(cur.b));
        delay = $urandom_range(0, 6);
        phase = core_hangs(cur) ? 3 : 2;
      end else if (phase == 2) begin
        check("wait_data_b", 32'(gcd_data_in), 32'(cur.b));
        if (delay == 0) begin
          gcd_done   = 1'b1;
          gcd_result = gcd_f(cur.a, cur.b);
          phase      = 0;
        end else begin
          delay--;
          gcd_result = WIDTH'($urandom);
        end
      end
    end
  end

  initial begin : global_watchdog
    #500000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "bench stalled");
  end

  // Called at posedge+1; returns at posedge+1 after the handshake.
  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    check("push_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit, input string name);
    int n = 0;
    while (!out_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_start(input int limit, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gcd_start && n < limit);
    check(name, 32'(gcd_start), 32'd1);
  endtask

  task automatic drain(input int limit, input string name);
    int n = 0;
    while ((res_q.size() != 0 || busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(res_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    issue_q.delete();
    res_q.delete();
    @(negedge clk);
    check("rst_in_ready",    32'(in_ready),    32'd1);
    check("rst_out_valid",   32'(out_valid),   32'd0);
    check("rst_out_gcd",     32'(out_gcd),     32'd0);
    check("rst_out_err",     32'(out_err),     32'd0);
    check("rst_gcd_start",   32'(gcd_start),   32'd0);
    check("rst_gcd_data_in", 32'(gcd_data_in), 32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_fifo_count",  32'(fifo_count),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : stim
    int exp6 [6];
    exp6 = '{3, 6, 1, 25, 27, 7};

    apply_reset();

    check("pin_gcd_143_78", 32'(gcd_f(16'd143, 16'd78)), 32'd13);
    check("pin_gcd_48_18",  32'(gcd_f(16'd48,  16'd18)), 32'd6);
    check("pin_gcd_100_75", 32'(gcd_f(16'd100, 16'd75)), 32'd25);
    check("pin_hang_err",   32'(expect_res({HANG_A, 16'd5}).err), 32'd1);

    // Single pair, consumer always ready.
    got_q.delete();
    out_ready = 1'b1;
    push(16'd143, 16'd78);
    wait_start(20, "t1_start_seen");
    check("t1_data_a", 32'(gcd_data_in), 32'd143);
    @(negedge clk);
    check("t1_start_one_cycle", 32'(gcd_start), 32'd0);
    check("t1_data_b", 32'(gcd_data_in), 32'd78);
    wait_valid(50, "t1_valid");
    check("t1_gcd", 32'(out_gcd), 32'd13);
    check("t1_err", 32'(out_err), 32'd0);
    drain(50, "t1_drain");
    check("t1_result_count", 32'(got_q.size()), 32'd1);

    // Fill the FIFO behind a held result, then push into the pop cycle.
    got_q.delete();
    out_ready = 1'b0;
    push(16'd9, 16'd6);
    wait_valid(50, "t2_blocker_valid");
    @(posedge clk);
    #1;
    push(16'd48, 16'd18);
    push(16'd17, 16'd5);
    push(16'd100, 16'd75);
    push(16'd81, 16'd27);
    @(negedge clk);
    check("t2_full_in_ready", 32'(in_ready), 32'd0);
    check("t2_full_count", 32'(fifo_count), 32'd4);
    @(posedge clk);
    #1;
    in_a      = 16'd35;
    in_b      = 16'd14;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("t6_in_ready_on_pop", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("t6_count_stays_full", 32'(fifo_count), 32'd4);
    drain(400, "t2_drain");
    check("t2_result_count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (got_q.size() > i) check("t2_order", 32'(got_q[i]), 32'(exp6[i]));
    end

    // Hung core: abort after the watchdog, next pair unaffected.
    got_q.delete();
    push(HANG_A, 16'd5);
    wait_start(20, "t3_start_seen");
    @(negedge clk);
    t_lb = $time;
    @(posedge clk);
    #1;
    push(16'd12, 16'd8);
    begin
      int n = 0;
      while (!out_valid && n < TIMEOUT + 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("t3_abort_latency", 32'(($time - t_lb) / 10), 32'(TIMEOUT + 1));
    check("t3_err", 32'(out_err), 32'd1);
    check("t3_gcd_zero", 32'(out_gcd), 32'd0);
    drain(200, "t3_drain");
    check("t3_result_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() > 1) check("t3_next_pair", 32'(got_q[1]), 32'd4);

    // Reset while waiting with two pairs queued.
    push(HANG_A, 16'd1);
    push(16'd6, 16'd4);
    push(16'd10, 16'd5);
    repeat (4) @(negedge clk);
    check("t4_busy_before_reset", 32'(busy), 32'd1);
    check("t4_count_before_reset", 32'(fifo_count), 32'd2);
    apply_reset();
    nstart = 0;
    repeat (20) begin
      @(negedge clk);
      if (gcd_start) nstart++;
    end
    check("t4_no_start_after_reset", 32'(nstart), 32'd0);
    check("t4_count_after_reset", 32'(fifo_count), 32'd0);
    check("t4_idle_after_reset", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Zero operand.
    got_q.delete();
    push(16'd0, 16'd42);
`ifdef GCD_ZERO_BYPASS_EN
    wait_valid(20, "t5_valid");
    check("t5_gcd", 32'(out_gcd), 32'd42);
    check("t5_err", 32'(out_err), 32'd0);
`else
    wait_valid(TIMEOUT + 20, "t5_valid");
    check("t5_gcd", 32'(out_gcd), 32'd0);
    check("t5_err", 32'(out_err), 32'd1);
`endif
    drain(200, "t5_drain");

    // Randomized traffic with random back-pressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          ra = ($urandom_range(0, 9) == 0) ? '0 : WIDTH'($urandom_range(1, 999));
          rb = ($urandom_range(0, 9) == 0) ? '0 : WIDTH'($urandom_range(1, 999));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          push(ra, rb);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain(5000, "rand_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
